// File: rtl/mmio_uart_tx.sv
// Store-bus snooping UART transmitter: stores to UART_ADDR feed a byte FIFO drained 8N1 on Tx.
// Define UART_PARITY_EN to add an even parity bit (8E1).
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] UART_ADDR    = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Mem_Write,
    input  logic [31:0] Data_Adr,
    input  logic [31:0] Write_Data,
    output logic        Tx,
    output logic        Tx_Busy,
    output logic        Fifo_Full,
    output logic        Fifo_Empty,
    output logic [7:0]  Drop_Count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_CNT   = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_drop;

    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_busy;
`ifdef UART_PARITY_EN
    logic          r_par;
`endif

    logic w_hit, w_full, w_empty, w_push, w_pop, w_unused;

    assign w_hit    = Mem_Write && (Data_Adr == UART_ADDR);
    assign w_full   = (r_count == DEPTH_CNT);
    assign w_empty  = (r_count == '0);
    assign w_push   = w_hit && !w_full;
    // Pop only from IDLE on the registered (pre-edge) occupancy
    assign w_pop    = (r_state == S_IDLE) && !w_empty;
    assign w_unused = ^Write_Data[31:8];

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= Write_Data[7:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_drop  <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            // A full FIFO drops the store even if a pop frees a slot on this edge
            if (w_hit && w_full && (r_drop != 8'hFF))
                r_drop <= r_drop + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
`ifdef UART_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
                        r_baud  <= BAUD_RELOAD;
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
`ifdef UART_PARITY_EN
                        r_par   <= ^r_mem[r_rptr];
`endif
                    end
                end
                S_START: begin
                    if (r_baud == '0) begin
                        r_baud  <= BAUD_RELOAD;
                        r_bit   <= '0;
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
                S_DATA: begin
                    if (r_baud == '0) begin
                        r_baud <= BAUD_RELOAD;
                        if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                            r_state <= S_PARITY;
                            r_tx    <= r_par;
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (r_baud == '0) begin
                        r_baud  <= BAUD_RELOAD;
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
`endif
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (r_baud == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Tx         = r_tx;
    assign Tx_Busy    = r_busy;
    assign Fifo_Full  = w_full;
    assign Fifo_Empty = w_empty;
    assign Drop_Count = r_drop;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level reference model with per-cycle compare plus directed literal checks.
// Builds with or without UART_PARITY_EN.
`timescale 1ns/1ps
module tb_mmio_uart_tx;
    localparam int          C  = 4;
    localparam int          D  = 4;
    localparam logic [31:0] UA = 32'hFFFF_FFF0;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic        clk = 1'b0, reset = 1'b0, Mem_Write = 1'b0;
    logic [31:0] Data_Adr = '0, Write_Data = '0;
    logic        Tx, Tx_Busy, Fifo_Full, Fifo_Empty;
    logic [7:0]  Drop_Count;

    mmio_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .UART_ADDR(UA)) dut (
        .clk(clk), .reset(reset), .Mem_Write(Mem_Write), .Data_Adr(Data_Adr),
        .Write_Data(Write_Data), .Tx(Tx), .Tx_Busy(Tx_Busy), .Fifo_Full(Fifo_Full),
        .Fifo_Empty(Fifo_Empty), .Drop_Count(Drop_Count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus "cycles into current frame"
    logic [7:0] mq[$];
    bit         m_act = 0;
    int         m_pos = 0, m_drop = 0, msz;
    logic [7:0] m_byte = '0;
    bit         mh;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    initial forever begin
        @(posedge clk);
        if (!reset) begin
            mq.delete();
            m_act = 0; m_pos = 0; m_drop = 0;
        end else begin
            mh  = Mem_Write && (Data_Adr == UA);
            msz = mq.size();
            if (m_act) begin
                m_pos++;
                if (m_pos == FB*C) m_act = 0;
            end else if (msz > 0) begin
                m_byte = mq.pop_front();
                m_act = 1; m_pos = 0;
            end
            if (mh) begin
                if (msz < D) mq.push_back(Write_Data[7:0]);
                else if (m_drop < 255) m_drop++;
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (chk_en) begin
            chk("m_tx",    Tx,         m_act ? frame_bit(m_byte, m_pos / C) : 1'b1);
            chk("m_busy",  Tx_Busy,    m_act);
            chk("m_full",  Fifo_Full,  mq.size() == D);
            chk("m_empty", Fifo_Empty, mq.size() == 0);
            chk("m_drop",  Drop_Count, m_drop);
        end
    end

    // Line receiver: decodes the DUT's Tx into bytes, mid-bit sampling
    logic [7:0] rxq[$];
    int         rx_pos = -1;
    logic [7:0] rx_b = '0;
    initial forever begin
        @(posedge clk); #1;
        if (!reset) rx_pos = -1;
        else if (rx_pos < 0) begin
            if (Tx === 1'b0) rx_pos = 0;
        end else begin
            rx_pos++;
            if ((rx_pos % C) == 1 && (rx_pos / C) >= 1 && (rx_pos / C) <= 8)
                rx_b[rx_pos/C - 1] = Tx;
            if (rx_pos == FB*C - 1) begin
                rxq.push_back(rx_b);
                rx_pos = -1;
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Mem_Write = 1'b1; Data_Adr = a; Write_Data = d;
        @(negedge clk);
        Mem_Write = 1'b0; Data_Adr = '0; Write_Data = '0;
    endtask

    logic smp[64];
    int   busy_n;
    // Stores one byte and records Tx for 50 cycles starting right after the pop edge
    task automatic send_capture(input logic [31:0] d);
        store(UA, d);
        chk("lat_tx_idle", Tx, 1'b1);
        chk("lat_empty",   Fifo_Empty, 1'b0);
        busy_n = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            smp[i] = Tx;
            if (Tx_Busy) busy_n++;
        end
    endtask

    task automatic idle_scan(input int n, output bit saw_low);
        saw_low = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (Tx !== 1'b1) saw_low = 1;
        end
    endtask

    logic exp_s[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    string ovf_s = "ABCDE";
    bit    low;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx",    Tx,         1'b1);
        chk("rst_busy",  Tx_Busy,    1'b0);
        chk("rst_full",  Fifo_Full,  1'b0);
        chk("rst_empty", Fifo_Empty, 1'b1);
        chk("rst_drop",  Drop_Count, 8'd0);
        chk_en = 1;
        @(negedge clk); reset = 1'b1;

        // Single byte 'A'
        rxq.delete();
        send_capture(32'h1234_5641);
        chk("start_fall", smp[0], 1'b0);
        for (int b = 0; b < 9; b++) begin
            chk($sformatf("A_bit%0d", b), smp[C*b + 1], exp_s[b]);
            chk($sformatf("A_bit%0d_end", b), smp[C*b + 3], exp_s[b]);
        end
`ifdef UART_PARITY_EN
        chk("A_par",  smp[C*9 + 1], 1'b0);
        chk("A_stop", smp[C*10 + 1], 1'b1);
        chk("A_busy", busy_n, 44);
`else
        chk("A_stop", smp[C*9 + 1], exp_s[9]);
        chk("A_busy", busy_n, 40);
`endif
        chk("A_rx_n", rxq.size(), 1);
        if (rxq.size() > 0) chk("A_rx", rxq[0], 8'h41);

        // Address filter
        store(32'hFFFF_FFF4, 32'h0000_0041);
        store(32'h0000_0010, 32'h0000_0041);
        idle_scan(50, low);
        chk("filt_tx",    low, 1'b0);
        chk("filt_empty", Fifo_Empty, 1'b1);
        chk("filt_drop",  Drop_Count, 8'd0);

        // Overflow: A..F back to back, upper data bits randomised
        rxq.delete();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            Mem_Write = 1'b1; Data_Adr = UA;
            Write_Data = {24'($urandom()), 8'(8'h41 + k)};
        end
        @(negedge clk);
        Mem_Write = 1'b0; Data_Adr = '0;
        chk("ovf_drop", Drop_Count, 8'd1);
        chk("ovf_full", Fifo_Full, 1'b1);
        repeat (230) @(negedge clk);
        chk("ovf_rx_n", rxq.size(), 5);
        for (int k = 0; k < 5 && k < rxq.size(); k++)
            chk($sformatf("ovf_rx%0d", k), rxq[k], ovf_s[k]);
        chk("ovf_empty", Fifo_Empty, 1'b1);

        // Saturation: continuous hits keep the FIFO full
        @(negedge clk);
        Mem_Write = 1'b1; Data_Adr = UA; Write_Data = 32'h0000_0058;
        repeat (305) @(negedge clk);
        Mem_Write = 1'b0; Data_Adr = '0;
        chk("sat_drop", Drop_Count, 8'd255);
        repeat (230) @(negedge clk);
        chk("sat_drop_hold", Drop_Count, 8'd255);
        chk("sat_empty", Fifo_Empty, 1'b1);

        // Reset during data bit 3 of 'U'
        rxq.delete();
        store(UA, 32'h0000_0055);
        for (int i = 0; i < 18; i++) begin @(posedge clk); #1; end
        chk("rst_mid_busy", Tx_Busy, 1'b1);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_tx",    Tx,         1'b1);
        chk("rst_mid_busy0", Tx_Busy,    1'b0);
        chk("rst_mid_empty", Fifo_Empty, 1'b1);
        chk("rst_mid_drop",  Drop_Count, 8'd0);
        @(negedge clk); reset = 1'b1;
        idle_scan(60, low);
        chk("rst_no_resid", low, 1'b0);
        chk("rst_rx_n", rxq.size(), 0);

`ifdef UART_PARITY_EN
        send_capture(32'h0000_0007);
        chk("p07_par",  smp[C*9 + 1], 1'b1);
        chk("p07_busy", busy_n, 44);
        send_capture(32'h0000_0003);
        chk("p03_par",  smp[C*9 + 1], 1'b0);
        chk("p03_stop", smp[C*10 + 1], 1'b1);
`endif

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
